// File: rtl/dual_issue_sched_if.sv
// Fetch-pair / decode-slot bundle between fetch, the hazard unit and decode.
// Counter signals exist only when SCHED_PERF_EN is defined.
interface dual_issue_sched_if;
  logic [31:0] instrf;
  logic [31:0] instrf2;
  logic [31:0] pcplus4f;
  logic        stalld;
  logic        flushd;
  logic [31:0] instrd;
  logic [31:0] instrd2;
  logic [31:0] pcplus4d;
  logic [31:0] pcplus4d2;
  logic        validd;
  logic        validd2;
  logic        stallf;
  logic        split;
`ifdef SCHED_PERF_EN
  logic [31:0] pair_cnt;
  logic [31:0] split_cnt;
`endif

  // Scheduler side
  modport slave (
    input  instrf, instrf2, pcplus4f, stalld, flushd,
    output instrd, instrd2, pcplus4d, pcplus4d2, validd, validd2, stallf, split
`ifdef SCHED_PERF_EN
    , output pair_cnt, split_cnt
`endif
  );

  // Fetch / hazard-unit / decode side
  modport master (
    output instrf, instrf2, pcplus4f, stalld, flushd,
    input  instrd, instrd2, pcplus4d, pcplus4d2, validd, validd2, stallf, split
`ifdef SCHED_PERF_EN
    , input pair_cnt, split_cnt
`endif
  );
endinterface

// File: rtl/dual_issue_sched.sv
// Dual-issue scheduler: decides whether the fetched instruction pair issues
// together into both decode slots or is split over two cycles.
// Optional feature macro: SCHED_PERF_EN (pair/split performance counters).
module dual_issue_sched (
  input logic               clk,
  input logic               reset,
  dual_issue_sched_if.slave bus
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  typedef struct packed {
    logic [4:0] wr;     // destination register, 0 when none
    logic       rd_rs;
    logic       rd_rt;
    logic       mem;
    logic       ctl;
  } cls_t;

  function automatic cls_t classify(input logic [5:0] op, input logic [4:0] rt,
                                    input logic [4:0] rd);
    cls_t c;
    c = '0;
    case (op)
      6'h00:                      begin c.wr = rd; c.rd_rs = 1'b1; c.rd_rt = 1'b1; end
      6'h08, 6'h0A, 6'h0C, 6'h0D: begin c.wr = rt; c.rd_rs = 1'b1; end
      6'h23:                      begin c.wr = rt; c.rd_rs = 1'b1; c.mem = 1'b1; end
      6'h2B:                      begin c.rd_rs = 1'b1; c.rd_rt = 1'b1; c.mem = 1'b1; end
      6'h04:                      begin c.rd_rs = 1'b1; c.rd_rt = 1'b1; c.ctl = 1'b1; end
      6'h02:                      c.ctl = 1'b1;
      default:                    c = '0;
    endcase
    return c;
  endfunction

  logic [0:0]  state_q, state_d;
  logic [31:0] instrd_q, instrd2_q, pcplus4d_q, pcplus4d2_q;
  logic        validd_q, validd2_q;
  logic [31:0] pc_inc;
  cls_t        c1, c2;
  logic        raw, waw, need_split;
  logic        issue_pair, issue_split, issue_hold;

  assign pc_inc = bus.pcplus4f + 32'd4;

  // Pair hazard classification and combinational fetch-stall / split flags
  always_comb begin
    c1 = classify(bus.instrf[31:26], bus.instrf[20:16], bus.instrf[15:11]);
    c2 = classify(bus.instrf2[31:26], bus.instrf2[20:16], bus.instrf2[15:11]);
    raw = (c1.wr != 5'd0) &&
          ((c2.rd_rs && (bus.instrf2[25:21] == c1.wr)) ||
           (c2.rd_rt && (bus.instrf2[20:16] == c1.wr)));
    waw = (c1.wr != 5'd0) && (c1.wr == c2.wr);
    need_split = raw || waw || (c1.mem && c2.mem) || c1.ctl;

    issue_pair  = (state_q == RUN)  && !need_split && !bus.stalld && !bus.flushd;
    issue_split = (state_q == RUN)  &&  need_split && !bus.stalld && !bus.flushd;
    issue_hold  = (state_q == HOLD) && !bus.stalld && !bus.flushd;

    state_d = state_q;
    if (bus.flushd)       state_d = RUN;
    else if (issue_split) state_d = HOLD;
    else if (issue_hold)  state_d = RUN;

    bus.stallf = !bus.flushd && (bus.stalld || ((state_q == RUN) && need_split));
    bus.split  = issue_split;
  end

  // Decode slot registers and scheduler state; flush beats stall beats issue
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      instrd_q    <= '0;
      instrd2_q   <= '0;
      pcplus4d_q  <= '0;
      pcplus4d2_q <= '0;
      validd_q    <= 1'b0;
      validd2_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (bus.flushd) begin
        instrd_q  <= '0;
        instrd2_q <= '0;
        validd_q  <= 1'b0;
        validd2_q <= 1'b0;
      end else if (issue_pair) begin
        instrd_q    <= bus.instrf;
        instrd2_q   <= bus.instrf2;
        pcplus4d_q  <= bus.pcplus4f;
        pcplus4d2_q <= pc_inc;
        validd_q    <= 1'b1;
        validd2_q   <= 1'b1;
      end else if (issue_split || issue_hold) begin
        // Slot 2 of a split pair is still in fetch, so HOLD issues it as slot 1
        instrd_q   <= issue_hold ? bus.instrf2 : bus.instrf;
        pcplus4d_q <= issue_hold ? pc_inc : bus.pcplus4f;
        validd_q   <= 1'b1;
        instrd2_q  <= '0;
        validd2_q  <= 1'b0;
      end
    end
  end

  assign bus.instrd    = instrd_q;
  assign bus.instrd2   = instrd2_q;
  assign bus.pcplus4d  = pcplus4d_q;
  assign bus.pcplus4d2 = pcplus4d2_q;
  assign bus.validd    = validd_q;
  assign bus.validd2   = validd2_q;

`ifdef SCHED_PERF_EN
  logic [31:0] pair_cnt_q, split_cnt_q;

  // Issue counters; stalled and flushed cycles are never counted
  always_ff @(posedge clk) begin
    if (reset) begin
      pair_cnt_q  <= '0;
      split_cnt_q <= '0;
    end else begin
      if (issue_pair)  pair_cnt_q  <= pair_cnt_q + 32'd1;
      if (issue_split) split_cnt_q <= split_cnt_q + 32'd1;
    end
  end

  assign bus.pair_cnt  = pair_cnt_q;
  assign bus.split_cnt = split_cnt_q;
`endif

endmodule

// File: tb/tb_dual_issue_sched.sv
// Self-checking bench for dual_issue_sched: directed pairs from the test plan
// plus a randomised run, checked against a scoreboard of expected decode state.
module tb_dual_issue_sched;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dual_issue_sched_if bus_if ();

  dual_issue_sched dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  typedef struct packed {
    logic [31:0] i1, i2, p1, p2;
    logic        v1, v2;
  } dec_t;

  dec_t   exp_q[$];
  dec_t   m_dec;
  logic   m_hold;
  int     m_pair, m_split;
  int     vectors = 0;
  int     miscompares = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference classification: {writes-reg, reads rs, reads rt, memory, control}
  function automatic logic [8:0] ref_cls(input logic [31:0] ins);
    logic [5:0] op;
    op = ins[31:26];
    if (op == 6'h00)                   return {ins[15:11], 4'b1100};
    if (op inside {6'h08, 6'h0A, 6'h0C, 6'h0D}) return {ins[20:16], 4'b1000};
    if (op == 6'h23)                   return {ins[20:16], 4'b1010};
    if (op == 6'h2B)                   return {5'd0, 4'b1110};
    if (op == 6'h04)                   return {5'd0, 4'b1101};
    if (op == 6'h02)                   return {5'd0, 4'b0001};
    return '0;
  endfunction

  function automatic logic ref_split(input logic [31:0] a, input logic [31:0] b);
    logic [8:0] ca, cb;
    logic [4:0] w;
    ca = ref_cls(a);
    cb = ref_cls(b);
    w  = ca[8:4];
    if (ca[0]) return 1'b1;
    if (ca[1] && cb[1]) return 1'b1;
    if (w == 5'd0) return 1'b0;
    if (cb[3] && b[25:21] == w) return 1'b1;
    if (cb[2] && b[20:16] == w) return 1'b1;
    return cb[8:4] == w;
  endfunction

  task automatic compare_out();
    dec_t e;
    if (exp_q.size() == 0) begin
      check_val("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check_val("instrd",  bus_if.instrd,  e.i1);
    check_val("instrd2", bus_if.instrd2, e.i2);
    check_val("pcplus4d", bus_if.pcplus4d, e.p1);
    if (e.v2) check_val("pcplus4d2", bus_if.pcplus4d2, e.p2);
    check_val("validd",  {31'd0, bus_if.validd},  {31'd0, e.v1});
    check_val("validd2", {31'd0, bus_if.validd2}, {31'd0, e.v2});
`ifdef SCHED_PERF_EN
    check_val("pair_cnt",  bus_if.pair_cnt,  m_pair);
    check_val("split_cnt", bus_if.split_cnt, m_split);
`endif
  endtask

  // One clock: drive fetch pair and hazard inputs, check comb flags, then the edge
  task automatic step(input logic [31:0] i1, input logic [31:0] i2, input logic [31:0] pc,
                      input logic st, input logic fl);
    logic nd;
    dec_t nx;
    bus_if.instrf   = i1;
    bus_if.instrf2  = i2;
    bus_if.pcplus4f = pc;
    bus_if.stalld   = st;
    bus_if.flushd   = fl;
    #1;
    nd = ref_split(i1, i2);
    check_val("stallf", {31'd0, bus_if.stallf}, {31'd0, (!fl && (st || (!m_hold && nd)))});
    if (!st && !fl)
      check_val("split", {31'd0, bus_if.split}, {31'd0, (!m_hold && nd)});
    nx = m_dec;
    if (fl) begin
      nx.i1 = '0; nx.i2 = '0; nx.v1 = 1'b0; nx.v2 = 1'b0;
      m_hold = 1'b0;
    end else if (!st) begin
      if (m_hold) begin
        nx.i1 = i2; nx.p1 = pc + 32'd4; nx.v1 = 1'b1; nx.i2 = '0; nx.v2 = 1'b0;
        m_hold = 1'b0;
      end else if (nd) begin
        nx.i1 = i1; nx.p1 = pc; nx.v1 = 1'b1; nx.i2 = '0; nx.v2 = 1'b0;
        m_hold = 1'b1;
        m_split++;
      end else begin
        nx = '{i1: i1, i2: i2, p1: pc, p2: pc + 32'd4, v1: 1'b1, v2: 1'b1};
        m_pair++;
      end
    end
    m_dec = nx;
    exp_q.push_back(nx);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  task automatic do_reset();
    bus_if.instrf = '0; bus_if.instrf2 = '0; bus_if.pcplus4f = '0;
    bus_if.stalld = 1'b0; bus_if.flushd = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_dec = '0; m_hold = 1'b0; m_pair = 0; m_split = 0;
    exp_q.delete();
    check_val("rst_instrd",  bus_if.instrd,  32'd0);
    check_val("rst_instrd2", bus_if.instrd2, 32'd0);
    check_val("rst_pc",      bus_if.pcplus4d, 32'd0);
    check_val("rst_pc2",     bus_if.pcplus4d2, 32'd0);
    check_val("rst_valid",   {30'd0, bus_if.validd, bus_if.validd2}, 32'd0);
    check_val("rst_stallf",  {31'd0, bus_if.stallf}, 32'd0);
`ifdef SCHED_PERF_EN
    check_val("rst_pair_cnt",  bus_if.pair_cnt,  32'd0);
    check_val("rst_split_cnt", bus_if.split_cnt, 32'd0);
`endif
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [9];
    logic [5:0] op;
    logic [4:0] rs, rt, rd;
    ops = '{6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h02};
    op = ops[$urandom_range(0, 8)];
    rs = 5'($urandom_range(0, 5));
    rt = 5'($urandom_range(0, 5));
    rd = 5'($urandom_range(0, 5));
    if (op == 6'h00) return {6'h00, rs, rt, rd, 5'd0, 6'h20};
    if (op == 6'h02) return {6'h02, 26'($urandom)};
    return {op, rs, rt, 16'($urandom)};
  endfunction

  localparam logic [31:0] ADD3 = 32'h00221820;
  localparam logic [31:0] ADD6 = 32'h00223020;
  localparam logic [31:0] ADD5 = 32'h00642820;
  localparam logic [31:0] LW   = 32'h8C270000;
  localparam logic [31:0] SW   = 32'hAC280004;
  localparam logic [31:0] BEQ  = 32'h10220003;

  initial begin
    logic [31:0] a, b, pc;
    logic        st, fl;
    reset = 1'b1;
    m_dec = '0; m_hold = 1'b0; m_pair = 0; m_split = 0;
    @(posedge clk);
    #1;
    do_reset();

    // Independent pair
    step(ADD3, ADD6, 32'h100, 1'b0, 1'b0);
    check_val("pair_instrd2", bus_if.instrd2, 32'h00223020);
    check_val("pair_pc2",     bus_if.pcplus4d2, 32'h104);

    // RAW pair: split, second cycle issues slot 2 at pc+4
    step(ADD3, ADD5, 32'h200, 1'b0, 1'b0);
    check_val("raw_c1_instrd", bus_if.instrd, 32'h00221820);
    step(ADD3, ADD5, 32'h200, 1'b0, 1'b0);
    check_val("raw_c2_instrd", bus_if.instrd, 32'h00642820);
    check_val("raw_c2_pc",     bus_if.pcplus4d, 32'h204);

    // Memory pair, control in slot 1, control in slot 2, $0 writer, WAW
    step(LW, SW, 32'h300, 1'b0, 1'b0);
    step(LW, SW, 32'h300, 1'b0, 1'b0);
    step(BEQ, ADD6, 32'h310, 1'b0, 1'b0);
    step(BEQ, ADD6, 32'h310, 1'b0, 1'b0);
    step(ADD3, 32'h08000010, 32'h320, 1'b0, 1'b0);
    step(32'h20200005, 32'h00021820, 32'h330, 1'b0, 1'b0);
    step(32'h20230001, 32'h34430002, 32'h340, 1'b0, 1'b0);
    step(32'h20230001, 32'h34430002, 32'h340, 1'b0, 1'b0);

    // Split then flush in HOLD: held slot 2 abandoned
    step(ADD3, ADD5, 32'h400, 1'b0, 1'b0);
    step(ADD3, ADD5, 32'h400, 1'b1, 1'b1);
    check_val("flush_valid", {30'd0, bus_if.validd, bus_if.validd2}, 32'd0);
    step(ADD3, ADD6, 32'h500, 1'b0, 1'b0);
    check_val("post_flush_instrd2", bus_if.instrd2, ADD6);

    // Split then stalld for 3 cycles in HOLD, then the held instruction issues once
    step(ADD3, ADD5, 32'h600, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(ADD3, ADD5, 32'h600, 1'b1, 1'b0);
    step(ADD3, ADD5, 32'h600, 1'b0, 1'b0);
    check_val("hold_release_instrd", bus_if.instrd, ADD5);
    step(ADD3, ADD6, 32'h608, 1'b0, 1'b0);

    // PC+4 wrap on slot 2
    step(ADD3, ADD6, 32'hFFFFFFFC, 1'b0, 1'b0);
    check_val("wrap_pc2", bus_if.pcplus4d2, 32'h00000000);

    // Reset in the middle of HOLD
    step(LW, SW, 32'h700, 1'b0, 1'b0);
    do_reset();

    // Counter totals: 4 pairs + 2 split pairs, then reset clears them
    for (int i = 0; i < 4; i++) step(ADD3, ADD6, 32'h800 + 32'(i * 8), 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(LW, SW, 32'h900, 1'b0, 1'b0);
      step(LW, SW, 32'h900, 1'b0, 1'b0);
    end
`ifdef SCHED_PERF_EN
    check_val("tot_pair_cnt",  bus_if.pair_cnt,  32'd4);
    check_val("tot_split_cnt", bus_if.split_cnt, 32'd2);
`endif
    do_reset();

    // Randomised traffic; fetch pair held whenever fetch was stalled
    a = rand_instr(); b = rand_instr(); pc = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      st = ($urandom_range(0, 7) == 0);
      fl = ($urandom_range(0, 15) == 0);
      step(a, b, pc, st, fl);
      if (!bus_if.stallf) begin
        a = rand_instr(); b = rand_instr(); pc = pc + 32'd8;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
